// File: rtl/cavlc_pkg.sv
// Shared types and constants for the CAVLC coefficient assembly path.
package cavlc_pkg;

    localparam int MAX_COEFF = 16;
    localparam int LEVEL_W   = 13;

    typedef logic signed [LEVEL_W-1:0] level_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        PLACE,
        OUTPUT
    } state_t;

    // MaxNumCoeff values by block type
    localparam logic [4:0] MNC_CHROMA_DC = 5'd4;
    localparam logic [4:0] MNC_AC        = 5'd15;
    localparam logic [4:0] MNC_LUMA      = 5'd16;

endpackage

// File: rtl/coeff_assembler_level_store.sv
// Small register file holding decoded levels in reverse scan order.
// Write port plus combinational read; synchronous clear wipes every entry.
module level_store
    import cavlc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 13,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_we,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge i_clk) begin
                if (i_clr) begin
                    r_mem[gi] <= '0;
                end else if (i_we && (i_wr_addr == AW'(gi))) begin
                    r_mem[gi] <= i_wr_data;
                end
            end
        end
    endgenerate

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/coeff_assembler.sv
// Collects CAVLC levels and total_zeros, places each level at its scan position
// using run_before values, and presents the 16-entry block over valid/ready.
module coeff_assembler
    import cavlc_pkg::*;
#(
    parameter int MAX_COEFF = cavlc_pkg::MAX_COEFF,
    parameter int LEVEL_W   = cavlc_pkg::LEVEL_W
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           Start,
    input  logic [4:0]                     TotalCoeff,
    input  logic [4:0]                     MaxNumCoeff,
    input  logic                           LevelWrReq,
    input  logic signed [LEVEL_W-1:0]      LevelIn,
    input  logic                           TotalZerosValid,
    input  logic [3:0]                     TotalZeros,
    input  logic                           RunValid,
    input  logic [3:0]                     RunBefore,
    output logic                           RunReady,
    output logic [MAX_COEFF*LEVEL_W-1:0]   CoeffOut,
    output logic                           BlockValid,
    input  logic                           BlockReady,
    output logic                           Busy,
    output logic                           Error
);

    localparam int         AW    = $clog2(MAX_COEFF);
    localparam logic [5:0] MAXC6 = 6'(MAX_COEFF);

    state_t r_state, w_state_next;
    logic [4:0] r_num_coef, w_num_coef_next;
    logic [4:0] r_max, w_max_next;
    logic [4:0] r_lvl_cnt, w_lvl_cnt_next;
    logic       r_tz_seen, w_tz_seen_next;
    logic [3:0] r_tz, w_tz_next;
    logic [4:0] r_i, w_i_next;
    logic [3:0] r_zeros_left, w_zeros_left_next;
    logic [5:0] r_pos, w_pos_next;
    logic       r_error, w_error_next;
    logic signed [LEVEL_W-1:0] r_coeff [MAX_COEFF];
    logic signed [LEVEL_W-1:0] w_coeff_next [MAX_COEFF];

    logic               w_we, w_store_clr, w_clr_any, w_run_needed, w_run_ready;
    logic [3:0]         w_run;
    logic [5:0]         w_sum;
    logic [LEVEL_W-1:0] w_rd_data;

    assign w_clr_any = Reset || w_store_clr;

    level_store #(.DEPTH(MAX_COEFF), .WIDTH(LEVEL_W)) u_level_store (
        .i_clk     (Clk),
        .i_clr     (w_clr_any),
        .i_we      (w_we),
        .i_wr_addr (r_lvl_cnt[AW-1:0]),
        .i_wr_data (LevelIn),
        .i_rd_addr (r_i[AW-1:0]),
        .o_rd_data (w_rd_data)
    );

    assign w_sum        = {1'b0, r_num_coef} + {2'b00, r_tz};
    assign w_run_needed = (r_i < (r_num_coef - 5'd1)) && (r_zeros_left != 4'd0);

    always_comb begin
        w_state_next      = r_state;
        w_num_coef_next   = r_num_coef;
        w_max_next        = r_max;
        w_lvl_cnt_next    = r_lvl_cnt;
        w_tz_seen_next    = r_tz_seen;
        w_tz_next         = r_tz;
        w_i_next          = r_i;
        w_zeros_left_next = r_zeros_left;
        w_pos_next        = r_pos;
        w_error_next      = r_error;
        w_coeff_next      = r_coeff;
        w_we              = 1'b0;
        w_store_clr       = 1'b0;
        w_run_ready       = 1'b0;
        w_run             = '0;

        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_num_coef_next = TotalCoeff;
                    w_max_next      = MaxNumCoeff;
                    w_lvl_cnt_next  = '0;
                    w_tz_seen_next  = 1'b0;
                    w_tz_next       = '0;
                    w_i_next        = '0;
                    w_error_next    = 1'b0;
                    w_store_clr     = 1'b1;
                    w_coeff_next    = '{default: '0};
                    w_state_next    = (TotalCoeff == 5'd0) ? OUTPUT : COLLECT;
                end
            end

            COLLECT: begin
                // A level beyond the announced count is dropped, never stored.
                if (LevelWrReq) begin
                    if ((r_lvl_cnt == r_num_coef) || ({1'b0, r_lvl_cnt} >= MAXC6)) begin
                        w_error_next = 1'b1;
                    end else begin
                        w_we           = 1'b1;
                        w_lvl_cnt_next = r_lvl_cnt + 5'd1;
                    end
                end
                if ((r_lvl_cnt == r_num_coef) && r_tz_seen) begin
                    if (w_sum > {1'b0, r_max}) begin
                        w_error_next = 1'b1;
                        w_state_next = OUTPUT;
                    end else begin
                        w_state_next      = PLACE;
                        w_i_next          = '0;
                        w_zeros_left_next = r_tz;
                        w_pos_next        = w_sum - 6'd1;
                    end
                end else if (TotalZerosValid) begin
                    w_tz_next      = TotalZeros;
                    w_tz_seen_next = 1'b1;
                end
            end

            PLACE: begin
                w_run_ready = w_run_needed;
                if (!w_run_needed || RunValid) begin
                    if (r_pos < MAXC6) begin
                        w_coeff_next[r_pos[AW-1:0]] = w_rd_data;
                    end
                    w_run = w_run_needed ? RunBefore : 4'd0;
                    if (w_run > r_zeros_left) begin
                        w_error_next = 1'b1;
                        w_run        = r_zeros_left;
                    end
                    w_pos_next        = r_pos - 6'(w_run) - 6'd1;
                    w_zeros_left_next = r_zeros_left - w_run;
                    w_i_next          = r_i + 5'd1;
                    if (r_i == (r_num_coef - 5'd1)) begin
                        w_state_next = OUTPUT;
                    end
                end
            end

            OUTPUT: begin
                if (BlockReady) begin
                    w_state_next = IDLE;
                end
            end

            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_num_coef   <= '0;
            r_max        <= '0;
            r_lvl_cnt    <= '0;
            r_tz_seen    <= 1'b0;
            r_tz         <= '0;
            r_i          <= '0;
            r_zeros_left <= '0;
            r_pos        <= '0;
            r_error      <= 1'b0;
            r_coeff      <= '{default: '0};
        end else begin
            r_state      <= w_state_next;
            r_num_coef   <= w_num_coef_next;
            r_max        <= w_max_next;
            r_lvl_cnt    <= w_lvl_cnt_next;
            r_tz_seen    <= w_tz_seen_next;
            r_tz         <= w_tz_next;
            r_i          <= w_i_next;
            r_zeros_left <= w_zeros_left_next;
            r_pos        <= w_pos_next;
            r_error      <= w_error_next;
            r_coeff      <= w_coeff_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_COEFF; gi++) begin : g_pack
            assign CoeffOut[gi*LEVEL_W +: LEVEL_W] = r_coeff[gi];
        end
    endgenerate

    assign RunReady   = w_run_ready;
    assign BlockValid = (r_state == OUTPUT);
    assign Busy       = (r_state != IDLE);
    assign Error      = r_error;

endmodule

// File: tb/tb_coeff_assembler.sv
// Directed bench for coeff_assembler: expected blocks go into a scoreboard
// queue when a block is started and are compared when the block is handed off.
module tb_coeff_assembler;
    import cavlc_pkg::*;

    localparam int W  = LEVEL_W;
    localparam int N  = MAX_COEFF;
    localparam int BW = N * W;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic [4:0]    TotalCoeff = '0;
    logic [4:0]    MaxNumCoeff = '0;
    logic          LevelWrReq = 1'b0;
    logic signed [W-1:0] LevelIn = '0;
    logic          TotalZerosValid = 1'b0;
    logic [3:0]    TotalZeros = '0;
    logic          RunValid;
    logic [3:0]    RunBefore;
    logic          RunReady;
    logic [BW-1:0] CoeffOut;
    logic          BlockValid;
    logic          BlockReady = 1'b0;
    logic          Busy;
    logic          Error;

    coeff_assembler dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Start           (Start),
        .TotalCoeff      (TotalCoeff),
        .MaxNumCoeff     (MaxNumCoeff),
        .LevelWrReq      (LevelWrReq),
        .LevelIn         (LevelIn),
        .TotalZerosValid (TotalZerosValid),
        .TotalZeros      (TotalZeros),
        .RunValid        (RunValid),
        .RunBefore       (RunBefore),
        .RunReady        (RunReady),
        .CoeffOut        (CoeffOut),
        .BlockValid      (BlockValid),
        .BlockReady      (BlockReady),
        .Busy            (Busy),
        .Error           (Error)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [BW-1:0] coeff;
        logic          err;
    } exp_t;

    exp_t sb_q[$];
    int   run_q[$];
    int   run_delay = 0;
    int   checks = 0;
    int   errors = 0;
    int   runs_taken = 0;
    int   rr_cycles = 0;

    always @(negedge Clk) begin
        if (RunReady && RunValid) runs_taken <= runs_taken + 1;
        if (RunReady) rr_cycles <= rr_cycles + 1;
    end

    // run_before source: presents queued runs, optionally after a delay
    initial begin
        int waited;
        RunValid  = 1'b0;
        RunBefore = '0;
        @(posedge Clk); #1;
        forever begin
            if (run_q.size() == 0) begin
                @(posedge Clk); #1;
            end else begin
                for (int d = 0; d < run_delay; d++) begin
                    @(posedge Clk); #1;
                end
                RunBefore = 4'(run_q.pop_front());
                RunValid  = 1'b1;
                waited = 0;
                do begin
                    @(negedge Clk);
                    waited++;
                end while (!RunReady && waited < 2000);
                @(posedge Clk); #1;
                RunValid = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int k, input int v);
        logic [BW-1:0] r;
        r = b;
        r[k*W +: W] = W'(v);
        return r;
    endfunction

    task automatic tick();
        @(posedge Clk); #1;
    endtask

    task automatic push_exp(input logic [BW-1:0] c, input logic e);
        exp_t x;
        x.coeff = c;
        x.err   = e;
        sb_q.push_back(x);
    endtask

    task automatic start_blk(input int tc, input logic [4:0] mx);
        Start = 1'b1;
        TotalCoeff = 5'(tc);
        MaxNumCoeff = mx;
        tick();
        Start = 1'b0;
    endtask

    task automatic lvl(input int v);
        LevelWrReq = 1'b1;
        LevelIn = W'(v);
        tick();
        LevelWrReq = 1'b0;
    endtask

    task automatic tzv(input int v);
        TotalZerosValid = 1'b1;
        TotalZeros = 4'(v);
        tick();
        TotalZerosValid = 1'b0;
    endtask

    // Wait for the block, optionally hold off BlockReady, then accept and compare.
    task automatic get_blk(input string tag, input int hold, input int exp_lat);
        int n;
        logic [BW-1:0] cap;
        exp_t e;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!BlockValid && n < 400);
        chk_i({tag, " valid"}, int'(BlockValid), 1);
        if (exp_lat >= 0) chk_i({tag, " latency"}, n, exp_lat);
        cap = CoeffOut;
        for (int h = 0; h < hold; h++) begin
            @(negedge Clk);
            chk_i({tag, " hold valid"}, int'(BlockValid), 1);
            chk({tag, " hold data"}, CoeffOut, cap);
        end
        BlockReady = 1'b1;
        e = sb_q.pop_front();
        chk({tag, " coeff"}, CoeffOut, e.coeff);
        chk_i({tag, " error"}, int'(Error), int'(e.err));
        $display("block %s: coeff=%h err=%b cycles=%0d", tag, CoeffOut, Error, n);
        tick();
        BlockReady = 1'b0;
        chk_i({tag, " valid drop"}, int'(BlockValid), 0);
        chk_i({tag, " idle"}, int'(Busy), 0);
    endtask

    task automatic std_stim();
        run_q.push_back(1);
        run_q.push_back(0);
        run_q.push_back(0);
        run_q.push_back(1);
        start_blk(5, MNC_LUMA);
        lvl(1);
        lvl(-1);
        lvl(-1);
        lvl(1);
        lvl(3);
        tzv(3);
    endtask

    initial begin
        logic [BW-1:0] std_exp;
        logic [BW-1:0] e;
        int r0;
        int q0;

        std_exp = '0;
        std_exp = put(std_exp, 1, 3);
        std_exp = put(std_exp, 3, 1);
        std_exp = put(std_exp, 4, -1);
        std_exp = put(std_exp, 5, -1);
        std_exp = put(std_exp, 7, 1);

        repeat (3) tick();
        Reset = 1'b0;
        chk_i("reset RunReady", int'(RunReady), 0);
        chk_i("reset BlockValid", int'(BlockValid), 0);
        chk_i("reset Busy", int'(Busy), 0);
        chk_i("reset Error", int'(Error), 0);
        chk("reset CoeffOut", CoeffOut, '0);
        tick();

        // Standard example, runs always available
        run_delay = 0;
        r0 = runs_taken;
        push_exp(std_exp, 1'b0);
        std_stim();
        get_blk("standard", 0, 7);
        chk_i("standard runs", runs_taken - r0, 4);

        // TotalCoeff = 0
        q0 = rr_cycles;
        push_exp('0, 1'b0);
        start_blk(0, MNC_LUMA);
        get_blk("tc0", 0, 1);
        chk_i("tc0 runready", rr_cycles - q0, 0);

        // Zero total_zeros, sent before the levels
        q0 = rr_cycles;
        e = '0;
        e = put(e, 0, 7);
        e = put(e, 1, -2);
        e = put(e, 2, 5);
        push_exp(e, 1'b0);
        start_blk(3, MNC_AC);
        tzv(0);
        lvl(5);
        lvl(-2);
        lvl(7);
        get_blk("tz0", 0, 5);
        chk_i("tz0 runready", rr_cycles - q0, 0);

        // Run stalls plus downstream backpressure
        run_delay = 4;
        r0 = runs_taken;
        push_exp(std_exp, 1'b0);
        std_stim();
        get_blk("stall", 10, -1);
        chk_i("stall runs", runs_taken - r0, 4);
        run_delay = 0;

        // Too many coefficients for the block type
        push_exp('0, 1'b1);
        start_blk(15, MNC_LUMA);
        tzv(2);
        for (int k = 0; k < 15; k++) lvl(k + 1);
        get_blk("overflow", 0, 2);

        // run_before larger than the zeros left gets clamped
        r0 = runs_taken;
        e = '0;
        e = put(e, 2, 4);
        e = put(e, 0, -6);
        push_exp(e, 1'b1);
        run_q.push_back(3);
        start_blk(2, MNC_LUMA);
        lvl(4);
        lvl(-6);
        tzv(1);
        get_blk("clamp", 0, -1);
        chk_i("clamp runs", runs_taken - r0, 1);

        // Surplus level is dropped and flagged
        e = '0;
        e = put(e, 0, 9);
        push_exp(e, 1'b1);
        start_blk(1, MNC_CHROMA_DC);
        lvl(9);
        lvl(8);
        tzv(0);
        get_blk("extra level", 0, 3);

        // Reset while placing
        start_blk(3, MNC_LUMA);
        tzv(0);
        lvl(5);
        lvl(-2);
        lvl(7);
        tick();
        tick();
        chk("midplace entry2", CoeffOut[2*W +: W], BW'(5));
        chk_i("midplace busy", int'(Busy), 1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk_i("post-reset Busy", int'(Busy), 0);
        chk_i("post-reset BlockValid", int'(BlockValid), 0);
        chk_i("post-reset Error", int'(Error), 0);
        chk("post-reset CoeffOut", CoeffOut, '0);
        $display("reset applied during PLACE");

        r0 = runs_taken;
        push_exp(std_exp, 1'b0);
        std_stim();
        get_blk("after reset", 0, 7);
        chk_i("after reset runs", runs_taken - r0, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
